// File: rtl/calc_operand_datapath.sv
// Calculator datapath: digit-wise operand entry, opcode latch, registered ALU
// result with flags, and a phase-selected display value.
module calc_operand_datapath #(
    parameter int W     = 16,
    parameter int DIG_W = 4,
    localparam int NDIG = W / DIG_W,
    localparam int CW   = $clog2(NDIG + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_1,
    input  logic             trigger_2,
    input  logic             trigger_op,
    input  logic [1:0]       estado,
    input  logic [DIG_W-1:0] digit_in,
    input  logic [2:0]       opcode_in,
    output logic [W-1:0]     display,
    output logic [W-1:0]     result,
    output logic             result_valid,
    output logic [3:0]       flags,
    output logic [CW-1:0]    ndig_a,
    output logic [CW-1:0]    ndig_b
);

    localparam logic [1:0] PH_A   = 2'd0;
    localparam logic [1:0] PH_B   = 2'd1;
    localparam logic [1:0] PH_OP  = 2'd2;
    localparam logic [1:0] PH_RES = 2'd3;

    localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

    logic [W-1:0] op_a, op_b;
    logic [2:0]   opcode;
    logic [1:0]   estado_q;

    logic         clear, compute, cap_a, cap_b;
    logic [W:0]   sum, diff;
    logic [W-1:0] alu_r;
    logic         alu_c, alu_v;

    // Re-entering phase 0 from anywhere starts a fresh calculation.
    assign clear   = (estado == PH_A) && (estado_q != PH_A);
    assign compute = (estado == PH_RES) && (estado_q != PH_RES);
    assign cap_a   = trigger_1 && (estado == PH_A) && (ndig_a < NDIG_C);
    assign cap_b   = trigger_2 && (estado == PH_B) && (ndig_b < NDIG_C);

    always_comb begin
        sum   = {1'b0, op_a} + {1'b0, op_b};
        diff  = {1'b0, op_a} - {1'b0, op_b};
        alu_r = op_a;
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (opcode)
            3'b000: begin
                alu_r = sum[W-1:0];
                alu_c = sum[W];
                alu_v = (op_a[W-1] == op_b[W-1]) && (alu_r[W-1] != op_a[W-1]);
            end
            3'b001: begin
                // diff[W] is the borrow: set exactly when A < B unsigned
                alu_r = diff[W-1:0];
                alu_c = diff[W];
                alu_v = (op_a[W-1] != op_b[W-1]) && (alu_r[W-1] != op_a[W-1]);
            end
            3'b010:  alu_r = op_a & op_b;
            3'b011:  alu_r = op_a | op_b;
            3'b100:  alu_r = op_a ^ op_b;
            3'b101:  alu_r = op_a << op_b[3:0];
            3'b110:  alu_r = op_a >> op_b[3:0];
            default: alu_r = op_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a         <= '0;
            op_b         <= '0;
            ndig_a       <= '0;
            ndig_b       <= '0;
            opcode       <= '0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
            estado_q     <= PH_A;
        end else begin
            estado_q <= estado;
            if (clear) begin
                op_a         <= '0;
                op_b         <= '0;
                ndig_a       <= '0;
                ndig_b       <= '0;
                opcode       <= '0;
                result       <= '0;
                flags        <= '0;
                result_valid <= 1'b0;
            end else begin
                if (cap_a) begin
                    op_a   <= {op_a[W-DIG_W-1:0], digit_in};
                    ndig_a <= ndig_a + CW'(1);
                end
                if (cap_b) begin
                    op_b   <= {op_b[W-DIG_W-1:0], digit_in};
                    ndig_b <= ndig_b + CW'(1);
                end
                if (trigger_op && (estado == PH_OP))
                    opcode <= opcode_in;
                if (compute) begin
                    result       <= alu_r;
                    flags        <= {alu_c, (alu_r == '0), alu_r[W-1], alu_v};
                    result_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        display = '0;
        case (estado)
            PH_A:    display = op_a;
            PH_B:    display = op_b;
            PH_OP:   display = {{(W-3){1'b0}}, opcode};
            default: display = result_valid ? result : '0;
        endcase
    end

endmodule
